// File: rtl/uart_mem_bridge_if.sv
// Request/response and UART FIFO signal bundle for uart_mem_bridge.
//   slave  : the bridge's view (takes requests, drives the UART push/pop flags).
//   master : the surrounding system's view (CPU request side plus the uart block).
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata : single-word request
//   resp_done/resp_err/resp_rdata                 : completion pulse, status, read data
//   uart_send_flag/uart_send_data/uart_send_able  : push into UART send FIFO
//   uart_recv_flag/uart_recv_data/uart_recv_able  : pop from UART recv FIFO
interface uart_mem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        uart_send_flag;
    logic [7:0]  uart_send_data;
    logic        uart_send_able;
    logic        uart_recv_flag;
    logic [7:0]  uart_recv_data;
    logic        uart_recv_able;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  uart_send_able, uart_recv_data, uart_recv_able,
        output req_ready, resp_done, resp_err, resp_rdata,
        output uart_send_flag, uart_send_data, uart_recv_flag
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output uart_send_able, uart_recv_data, uart_recv_able,
        input  req_ready, resp_done, resp_err, resp_rdata,
        input  uart_send_flag, uart_send_data, uart_recv_flag
    );
endinterface

// File: rtl/uart_mem_bridge.sv
// Bridges single-word memory requests onto byte-wide UART FIFOs.
// A request is sent as an opcode byte (01 read / 02 write), four little-endian
// address bytes and, for writes, four little-endian data bytes. A read then
// collects a four-byte little-endian reply, aborting after timeout_cycles idle
// cycles (0 disables the timeout).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_mem_bridge_if.slave (request, response and UART FIFO signals)
module uart_mem_bridge #(
    parameter int unsigned timeout_cycles = 100000000
) (
    input logic              clk,
    input logic              rst,
    uart_mem_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSendOp,
        StSendAddr,
        StSendData,
        StRecvData,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] rx_q;      // reply bytes 0..2; byte 3 goes straight to resp_rdata
    logic [31:0] cnt_q;
    logic        resp_done_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        send_flag;
    logic [7:0]  send_data;
    logic        recv_flag;
    logic        req_ready;
    logic        pop;
    logic        last_byte;
    logic        timeout_hit;

    always_comb begin
        pop         = (state_q == StRecvData) && bus.uart_recv_able;
        last_byte   = (idx_q == 2'd3);
        // Counter value cnt_q+1 is what the register would hold after this edge.
        timeout_hit = (timeout_cycles != 0) && (state_q == StRecvData) &&
                      !bus.uart_recv_able && ((cnt_q + 32'd1) == timeout_cycles);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (bus.req_valid) state_d = StSendOp;
            StSendOp:   if (send_flag) state_d = StSendAddr;
            StSendAddr: if (send_flag && last_byte) state_d = we_q ? StSendData : StRecvData;
            StSendData: if (send_flag && last_byte) state_d = StDone;
            StRecvData: if ((pop && last_byte) || timeout_hit) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        send_flag = 1'b0;
        send_data = 8'h00;
        req_ready = (state_q == StIdle);
        // Outside RECV_DATA any popped byte is stray and discarded, so the
        // pop flag simply tracks FIFO occupancy in every state.
        recv_flag = bus.uart_recv_able;
        unique case (state_q)
            StSendOp: begin
                send_flag = bus.uart_send_able;
                send_data = we_q ? 8'h02 : 8'h01;
            end
            StSendAddr: begin
                send_flag = bus.uart_send_able;
                send_data = 8'(addr_q >> {idx_q, 3'b000});
            end
            StSendData: begin
                send_flag = bus.uart_send_able;
                send_data = 8'(wdata_q >> {idx_q, 3'b000});
            end
            default: ;
        endcase
    end

    // Request latch, byte index, reply assembly, timeout counter, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= 2'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rx_q         <= 24'd0;
            cnt_q        <= 32'd0;
            resp_done_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_done_q <= 1'b0;

            if ((state_q == StIdle) && bus.req_valid) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end

            // The index wraps 3 -> 0 exactly when a phase ends, so each phase
            // starts at byte 0 without an explicit clear.
            if ((state_q == StIdle) || timeout_hit) begin
                idx_q <= 2'd0;
            end else if ((send_flag && (state_q != StSendOp)) || pop) begin
                idx_q <= idx_q + 2'd1;
            end

            cnt_q <= ((state_q == StRecvData) && !pop) ? cnt_q + 32'd1 : 32'd0;

            if ((state_q == StSendAddr) && (state_d == StRecvData)) begin
                rx_q <= 24'd0;
            end else if (pop && !last_byte) begin
                case (idx_q)
                    2'd0:    rx_q[7:0]   <= bus.uart_recv_data;
                    2'd1:    rx_q[15:8]  <= bus.uart_recv_data;
                    default: rx_q[23:16] <= bus.uart_recv_data;
                endcase
            end

            if ((state_q == StSendData) && (state_d == StDone)) begin
                resp_done_q <= 1'b1;
                resp_err_q  <= 1'b0;
            end else if ((state_q == StRecvData) && (state_d == StDone)) begin
                resp_done_q <= 1'b1;
                if (timeout_hit) begin
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'd0;
                end else begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= {bus.uart_recv_data, rx_q};
                end
            end
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_done      = resp_done_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.uart_send_flag = send_flag;
    assign bus.uart_send_data = send_data;
    assign bus.uart_recv_flag = recv_flag;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: directed cases followed by random
// requests, with a UART FIFO / remote-peer model and a frame-level reference.
module tb_uart_mem_bridge;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_mem_bridge_if bus ();

    uart_mem_bridge #(.timeout_cycles(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  reply_q[$];
    logic [7:0]  sent_q[$];
    int          sent_cyc[$];
    logic [7:0]  rep [4];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ready_rel = -1;
    int          done_cnt = 0;
    int          done_rel = 0;
    logic        done_err = 1'b0;
    logic [31:0] done_rdata = 32'd0;
    int          send_mode = 0;   // 0 always able, 1 able on odd cycles, 2 random
    int          reply_mode = 0;  // 0 reply bytes back-to-back, 1 random gaps
    bit          reply_go = 1'b0;
    int          skip_run = 0;
    bit          pop_pend = 1'b0;
    int          viol = 0;
    logic [31:0] exp_rdata = 32'd0;

    // UART FIFOs and remote peer: sample mid-cycle, update just after the edge.
    always begin
        @(negedge clk);
        cyc++;
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.req_ready && ready_rel < 0 && cyc > acc_cyc) ready_rel = cyc - acc_cyc;
        if (bus.uart_send_flag) begin
            sent_q.push_back(bus.uart_send_data);
            sent_cyc.push_back(cyc - acc_cyc);
            if (!bus.uart_send_able) viol++;
        end
        if (bus.uart_recv_flag !== bus.uart_recv_able) viol++;
        pop_pend = bus.uart_recv_flag;
        if (bus.resp_done) begin
            done_cnt++;
            done_rel   = cyc - acc_cyc;
            done_err   = bus.resp_err;
            done_rdata = bus.resp_rdata;
        end
        @(posedge clk);
        #1;
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        if (!reply_go && sent_q.size() == 5 && sent_q[0] == 8'h01) reply_go = 1'b1;
        if (reply_go && reply_q.size() > 0) begin
            if (reply_mode == 1 && skip_run < 3 && $urandom_range(0, 2) == 0) begin
                skip_run++;
            end else begin
                skip_run = 0;
                rxq.push_back(reply_q.pop_front());
            end
        end
        bus.uart_recv_able = (rxq.size() > 0);
        bus.uart_recv_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
        case (send_mode)
            0:       bus.uart_send_able = 1'b1;
            1:       bus.uart_send_able = (((cyc + 1 - acc_cyc) % 2) == 1);
            default: bus.uart_send_able = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    // poke: 0 none, 1 extra request while busy, 2 stray recv bytes during send.
    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] w,
                          input int nrep, input int rmode, input int poke);
        int start;
        int n;
        reply_go   = 1'b0;
        skip_run   = 0;
        reply_mode = rmode;
        reply_q.delete();
        for (int i = 0; i < nrep; i++) reply_q.push_back(rep[i]);
        sent_q.delete();
        sent_cyc.delete();
        start         = done_cnt;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = w;
        bus.req_valid = 1'b1;
        step();
        ready_rel     = -1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        if (poke == 1) begin
            step();
            bus.req_valid = 1'b1;
            repeat (3) step();
            bus.req_valid = 1'b0;
        end else if (poke == 2) begin
            rx_push(8'($urandom));
            step();
            rx_push(8'($urandom));
        end
        n = 0;
        while (done_cnt == start && n < 400) begin
            step();
            n++;
        end
        step();
        step();
        chk("done_count", done_cnt - start, 1);
    endtask

    // Reference frame: opcode, address LE, then data LE for writes.
    task automatic check_frame(input bit we, input logic [31:0] a, input logic [31:0] w,
                               input bit timed, input int stride);
        int n;
        logic [31:0] e;
        logic [31:0] o;
        n = we ? 9 : 5;
        chk("frame_len", sent_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) e = we ? 32'd2 : 32'd1;
            else if (i < 5) e = (a >> (8 * (i - 1))) & 32'hFF;
            else e = (w >> (8 * (i - 5))) & 32'hFF;
            o = (i < sent_q.size()) ? {24'd0, sent_q[i]} : 32'hFFFF_FFFF;
            chk($sformatf("frame_byte%0d", i), o, e);
            if (timed) begin
                o = (i < sent_cyc.size()) ? sent_cyc[i] : 32'hFFFF_FFFF;
                chk($sformatf("push_cycle%0d", i), o, stride * i + 1);
            end
        end
    endtask

    function automatic logic [31:0] le_word();
        return 32'(rep[0]) + (32'(rep[1]) << 8) + (32'(rep[2]) << 16) + (32'(rep[3]) << 24);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          we;
        logic [31:0] a;
        logic [31:0] w;
        int          d0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        // Reset values, including the drain flag following recv occupancy.
        step();
        step();
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_done", bus.resp_done, 0);
        chk("rst_err", bus.resp_err, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_send_flag", bus.uart_send_flag, 0);
        chk("rst_send_data", bus.uart_send_data, 0);
        chk("rst_recv_flag_empty", bus.uart_recv_flag, 0);
        rx_push(8'h55);
        step();
        chk("rst_recv_flag_full", bus.uart_recv_flag, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // Write, no stalls.
        do_req(1'b1, 32'h0000_1004, 32'hDEADBEEF, 0, 0, 0);
        check_frame(1'b1, 32'h0000_1004, 32'hDEADBEEF, 1'b1, 1);
        chk("wr_done_cycle", done_rel, 10);
        chk("wr_err", done_err, 0);
        chk("wr_ready_cycle", ready_rel, 11);
        chk("wr_rdata_kept", bus.resp_rdata, exp_rdata);

        // Read with reply available as soon as the frame is out.
        rep = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_req(1'b0, 32'h0000_0020, 32'd0, 4, 0, 0);
        exp_rdata = le_word();
        check_frame(1'b0, 32'h0000_0020, 32'd0, 1'b1, 1);
        chk("rd_done_cycle", done_rel, 10);
        chk("rd_err", done_err, 0);
        chk("rd_rdata", done_rdata, 32'h1234_5678);
        chk("rd_rdata_model", bus.resp_rdata, exp_rdata);

        // Alternating send backpressure plus a request offered while busy.
        send_mode = 1;
        do_req(1'b1, 32'hA5A5_0F0F, 32'h0123_4567, 0, 0, 1);
        send_mode = 0;
        check_frame(1'b1, 32'hA5A5_0F0F, 32'h0123_4567, 1'b1, 2);
        chk("bp_done_cycle", done_rel, 18);
        chk("bp_rdata_kept", bus.resp_rdata, exp_rdata);

        // Timeout: two reply bytes then silence; last pop in cycle 7, the
        // 16th idle edge afterwards raises resp_done, visible in cycle 24.
        rep = '{8'hC3, 8'h3C, 8'h00, 8'h00};
        do_req(1'b0, 32'h0000_0040, 32'd0, 2, 0, 0);
        exp_rdata = 32'd0;
        chk("to_done_cycle", done_rel, 24);
        chk("to_err", done_err, 1);
        chk("to_rdata", done_rdata, 0);

        // Stray bytes while idle and during the send phase are discarded.
        rx_push(8'hAA);
        step();
        rx_push(8'hBB);
        step();
        rx_push(8'hCC);
        repeat (4) step();
        chk("stray_drained", rxq.size(), 0);
        rep = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_req(1'b0, 32'h0000_0080, 32'd0, 4, 0, 2);
        exp_rdata = 32'h4433_2211;
        chk("stray_rdata", done_rdata, exp_rdata);
        chk("stray_err", done_err, 0);

        // Reset pulse in RECV_DATA after one reply byte.
        reply_go   = 1'b0;
        reply_mode = 0;
        reply_q.delete();
        reply_q.push_back(8'h9A);
        sent_q.delete();
        sent_cyc.delete();
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0100;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (8) step();
        chk("midrst_busy", bus.req_ready, 0);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.req_ready, 1);
        chk("midrst_no_done", bus.resp_done, 0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("midrst_done_count", done_cnt - d0, 0);
        exp_rdata = 32'd0;
        chk("midrst_rdata", bus.resp_rdata, exp_rdata);
        do_req(1'b1, 32'hCAFE_0004, 32'h89AB_CDEF, 0, 0, 0);
        check_frame(1'b1, 32'hCAFE_0004, 32'h89AB_CDEF, 1'b1, 1);
        chk("midrst_wr_done_cycle", done_rel, 10);
        chk("midrst_wr_err", done_err, 0);

        // Random requests with random send stalls and reply gaps.
        send_mode = 2;
        for (int t = 0; t < 24; t++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            w  = $urandom;
            for (int i = 0; i < 4; i++) rep[i] = 8'($urandom);
            do_req(we, a, w, 4, 1, $urandom_range(0, 2));
            check_frame(we, a, w, 1'b0, 0);
            if (!we) exp_rdata = le_word();
            chk("rand_err", done_err, 0);
            chk("rand_rdata", bus.resp_rdata, exp_rdata);
        end
        send_mode = 0;
        step();

        chk("handshake_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Bridges single-word memory requests onto the byte-wide UART FIFO interface. A write request is serialised as an opcode, address and data byte frame. A read request is serialised the same way, then the 4-byte reply is collected back into a 32-bit word. The block sits between the CPU memory-access stage and the `uart` block: it drives the `uart` send/recv flags and consumes its `send_able`/`recv_able`/`recv_data` outputs.

## Interface
Parameters:
- `timeout_cycles`, 100000000: cycles without a reply byte before a read aborts; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; equals (state == IDLE).
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  word address.
- `req_wdata`  in  32  write data.
- `resp_done`  out  1  one-cycle pulse when the request completes.
- `resp_err`  out  1  valid with `resp_done`; 1 = read timed out.
- `resp_rdata`  out  32  read data, valid with `resp_done`; held until the next completion.
- `uart_send_flag`  out  1  push `uart_send_data` into the UART send FIFO this cycle.
- `uart_send_data`  out  8  byte to send.
- `uart_send_able`  in  1  send FIFO not full.
- `uart_recv_flag`  out  1  pop the head of the UART recv FIFO this cycle.
- `uart_recv_data`  in  8  recv FIFO head, valid while `uart_recv_able`=1.
- `uart_recv_able`  in  1  recv FIFO not empty.

## Operation
- **Frame format** (bytes in order):
  - opcode: 8'h01 for read, 8'h02 for write;
  - `addr[7:0]`, `addr[15:8]`, `addr[23:16]`, `addr[31:24]`;
  - write only: `wdata[7:0]` … `wdata[31:24]`.
- **Read reply:** 4 bytes, little-endian, assembled as `rdata[7:0]` first. Writes get no reply.
- **States:** IDLE, SEND_OP, SEND_ADDR, SEND_DATA, RECV_DATA, DONE. A 2-bit byte index selects the current byte.
  - IDLE -> SEND_OP on `req_valid`. `req_we`, `req_addr` and `req_wdata` are latched on that edge.
  - SEND_OP -> SEND_ADDR after the opcode byte is pushed.
  - SEND_ADDR -> SEND_DATA (write) or RECV_DATA (read) after index 3 is pushed.
  - SEND_DATA -> DONE after index 3 is pushed.
  - RECV_DATA -> DONE after the 4th byte is popped, or on timeout.
  - DONE -> IDLE unconditionally.
- **Send handshake:** in SEND_* states, `uart_send_flag` = `uart_send_able` (combinational). `uart_send_data` is a combinational mux of the current byte. The index advances only on a cycle with `uart_send_flag`=1. `uart_send_flag` is 0 in all other states.
- **Receive handshake:** in RECV_DATA, `uart_recv_flag` = `uart_recv_able`. `uart_recv_data` is captured into the byte lane selected by the index on the same edge.
- **Drain:** in every state except RECV_DATA, `uart_recv_flag` = `uart_recv_able`, and popped bytes are discarded, so stray bytes never corrupt a later reply.
- **Timeout:** a 32-bit counter clears on entry to RECV_DATA and on every popped byte, and increments otherwise. When `timeout_cycles` != 0 and the counter reaches `timeout_cycles`:
  - go to DONE with `resp_err`=1 and `resp_rdata`=0;
  - partially received bytes are dropped.
- **DONE:** `resp_done`=1 for exactly one cycle. `resp_err`=0 on success. `resp_rdata` is updated only for reads; writes leave it unchanged.
- **Ignored requests:** `req_valid` while `req_ready`=0 is ignored. Requests are not queued.

## Timing
- **Reset values:**
  - state = IDLE, so `req_ready`=1;
  - `resp_done`=0, `resp_err`=0, `resp_rdata`=0;
  - `uart_send_flag`=0, `uart_send_data`=0;
  - `uart_recv_flag` follows the drain rule, so it is 0 unless `uart_recv_able`=1;
  - timeout counter = 0.
- **Reset mid-operation:** return to IDLE immediately; the partial frame is abandoned and no `resp_done` is issued.
- **Throughput:** at most one byte per cycle in each direction.
- **Write latency, no backpressure:** accept at edge 0; bytes pushed in cycles 1–9; `resp_done` in cycle 10; `req_ready`=1 in cycle 11.
- **Read latency, send never stalled and reply bytes always available:** bytes pushed in cycles 1–5; popped in cycles 6–9; `resp_done` in cycle 10.
- **Send stall:** each cycle with `uart_send_able`=0 in a SEND state adds one cycle and leaves the index unchanged.
- **Receive stall:** each cycle with `uart_recv_able`=0 in RECV_DATA adds one cycle.
- `resp_done`, `resp_err` and `resp_rdata` are registered outputs.

## Test plan
- **Write, no stalls:** write addr 32'h0000_1004, data 32'hDEADBEEF -> pushed bytes 02,04,10,00,00,EF,BE,AD,DE in cycles 1–9; `resp_done`=1, `resp_err`=0 in cycle 10.
- **Read, reply preloaded:** read addr 32'h0000_0020 with reply 78,56,34,12 -> pushed 01,20,00,00,00; `resp_rdata`=32'h12345678, `resp_err`=0.
- **Send backpressure:** `uart_send_able` low on alternating cycles during a write -> byte order unchanged, no push while low, completion in cycle 18.
- **Read timeout:** `timeout_cycles`=16; 2 reply bytes then silence -> `resp_done` with `resp_err`=1 and `resp_rdata`=0 exactly 16 cycles after the 2nd pop.
- **Stray bytes:** 3 bytes in the recv FIFO while IDLE, then a read -> the stray bytes are popped and discarded; the reply is assembled only from bytes arriving in RECV_DATA.
- **Reset mid-read:** `rst` pulse during RECV_DATA -> `req_ready`=1 immediately, no `resp_done`; the next write completes normally.
